// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, waits for lock, holds until lock is stable, then
// releases the core reset; lock timeouts and lock losses restart the PLL.
module pll_lock_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned LOSS_FILTER    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [3:0] retries,
  output logic [1:0] state
);

  localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B = (HOLD_CYCLES > LOSS_FILTER) ? HOLD_CYCLES : LOSS_FILTER;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_P = (MAX_C > SYNC_STAGES) ? MAX_C : SYNC_STAGES;
  localparam int unsigned CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int unsigned LW    = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILTER - 1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_n;
  logic                   retry_inc;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [CW-1:0]          cnt;
  logic [LW-1:0]          loss_cnt;

  // Only consumer of the asynchronous lock input.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], locked};
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_n   = state_r;
    retry_inc = 1'b0;
    case (state_r)
      S_RESET_PLL: if (cnt == RST_LAST) state_n = S_WAIT_LOCK;
      // Lock takes priority over a coincident timeout.
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = S_STABLE;
        end else if (cnt == TO_LAST) begin
          state_n   = S_RESET_PLL;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s)                 state_n = S_WAIT_LOCK;
        else if (cnt == HOLD_LAST)   state_n = S_RUN;
      end
      S_RUN: begin
        if (!lock_s && (loss_cnt == LOSS_LAST)) begin
          state_n   = S_RESET_PLL;
          retry_inc = 1'b1;
        end
      end
      default: state_n = S_RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_RESET_PLL;
      cnt      <= '0;
      loss_cnt <= '0;
      retries  <= 4'd0;
      pll_rst  <= 1'b1;
      core_rst <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (state_n != state_r)   cnt <= '0;
      else if (cnt != '1)       cnt <= cnt + CW'(1);
      if ((state_r == S_RUN) && (state_n == S_RUN) && !lock_s) loss_cnt <= loss_cnt + LW'(1);
      else                                                     loss_cnt <= '0;
      if (retry_inc && (retries != 4'hF)) retries <= retries + 4'd1;
      pll_rst  <= (state_n == S_RESET_PLL);
      core_rst <= (state_n != S_RUN);
      ready    <= (state_n == S_RUN);
    end
  end

  assign state = state_r;

endmodule
